// File: rtl/unsaved_button_capture_if.sv
// Avalon-MM slave bus bundle for the push-button input port.
// The master drives the address and strobes; the slave returns zero-latency read data.
interface unsaved_button_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/unsaved_button_capture.sv
// Push-button input port: per-bit 2-flop synchroniser, counter debouncer and edge capture
// with a maskable level interrupt, exposed as an Avalon-MM slave with zero read latency.
module unsaved_button_capture #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 16,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    unsaved_button_capture_if.slave  bus,
    input  logic [WIDTH-1:0]         in_port,
    output logic                     irq
);

    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // True when a debounced transition to new_level is one the port is configured to capture.
    function automatic logic edge_match(input logic new_level);
        case (EDGE_TYPE)
            0:       edge_match = new_level;
            1:       edge_match = !new_level;
            default: edge_match = 1'b1;
        endcase
    endfunction

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic             wr_en;

    always_comb begin
        stable_d = stable_q;
        edge_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
                edge_set[i] = edge_match(sync2_q[i]);
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // A new edge overrides a same-cycle write-1-to-clear on that bit.
    always_comb begin
        wr_en    = bus.chipselect && !bus.write_n;
        mask_d   = mask_q;
        edge_clr = '0;
        if (wr_en && (bus.address == ADDR_MASK)) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && (bus.address == ADDR_EDGE)) begin
            edge_clr = bus.writedata[WIDTH-1:0];
        end
        edge_d = (edge_q & ~edge_clr) | edge_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            stable_q <= RESET_LEVEL;
            edge_q   <= '0;
            mask_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect) begin
            case (bus.address)
                ADDR_DATA: bus.readdata[WIDTH-1:0] = stable_q;
                ADDR_MASK: bus.readdata[WIDTH-1:0] = mask_q;
                ADDR_EDGE: bus.readdata[WIDTH-1:0] = edge_q;
                default:   bus.readdata = '0;
            endcase
        end
    end

    assign irq = |(edge_q & mask_q);

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata;
            assign unused_wdata = ^bus.writedata[31:WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_unsaved_button_capture.sv
// Bench for unsaved_button_capture: register-access table, directed multi-cycle sequences
// and randomized traffic compared against a sliding-window reference model.
module tb_unsaved_button_capture;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int ET = 1;
    localparam logic [W-1:0] RL = 8'hFF;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_port;
    logic         irq;

    unsaved_button_capture_if bus_if ();

    unsaved_button_capture #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET), .RESET_LEVEL(RL)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_if), .in_port(in_port), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: in_port delayed two clocks, then a window of the last D
    // synchronised samples; a bit is accepted once every sample in the window disagrees.
    logic [W-1:0] m_s1, m_s2, m_stable, m_cap, m_mask;
    logic [W-1:0] m_hist [D];

    task automatic model_reset();
        m_s1 = RL; m_s2 = RL; m_stable = RL; m_cap = '0; m_mask = '0;
        for (int k = 0; k < D; k++) m_hist[k] = RL;
    endtask

    task automatic model_edge();
        logic [W-1:0] accept, newst, rises, falls, ev, clr;
        logic         wr;
        for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        accept = '1;
        for (int k = 0; k < D; k++) accept = accept & (m_hist[k] ^ m_stable);
        newst = m_stable ^ accept;
        rises = ~m_stable & newst;
        falls = m_stable & ~newst;
        ev = (ET == 0) ? rises : (ET == 1) ? falls : (rises | falls);
        wr  = bus_if.chipselect && !bus_if.write_n;
        clr = (wr && bus_if.address == 2'd3) ? bus_if.writedata[W-1:0] : '0;
        m_cap = (m_cap & ~clr) | ev;
        if (wr && bus_if.address == 2'd2) m_mask = bus_if.writedata[W-1:0];
        m_stable = newst;
        m_s2 = m_s1;
        m_s1 = in_port;
    endtask

    function automatic logic [31:0] model_rd();
        logic [31:0] r;
        r = '0;
        if (bus_if.chipselect) begin
            case (bus_if.address)
                2'd0: r[W-1:0] = m_stable;
                2'd2: r[W-1:0] = m_mask;
                2'd3: r[W-1:0] = m_cap;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_idle();
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
        bus_if.address = 2'd0;    bus_if.writedata = '0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1; bus_if.address = a;
        #1;
        chk(name, bus_if.readdata, exp);
        bus_idle();
    endtask

    task automatic wr_step(input logic [1:0] a, input logic [31:0] d);
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        bus_if.address = a;       bus_if.writedata = d;
        step();
        bus_idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'h000000FF, 1'b0};
        tbl[1]  = '{2'd1, 1'b1, 1'b1, 32'h0,        32'h00000000, 1'b0};
        tbl[2]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h00000000, 1'b0};
        tbl[3]  = '{2'd3, 1'b1, 1'b1, 32'h0,        32'h00000000, 1'b0};
        tbl[4]  = '{2'd0, 1'b0, 1'b1, 32'h0,        32'h00000000, 1'b0};
        tbl[5]  = '{2'd2, 1'b1, 1'b0, 32'h000000A5, 32'h00000000, 1'b0};
        tbl[6]  = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h000000A5, 1'b0};
        tbl[7]  = '{2'd0, 1'b1, 1'b0, 32'h00000012, 32'h000000FF, 1'b0};
        tbl[8]  = '{2'd0, 1'b1, 1'b1, 32'h0,        32'h000000FF, 1'b0};
        tbl[9]  = '{2'd1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        tbl[10] = '{2'd1, 1'b1, 1'b1, 32'h0,        32'h00000000, 1'b0};
        tbl[11] = '{2'd2, 1'b1, 1'b0, 32'hFFFFFF00, 32'h000000A5, 1'b0};
        tbl[12] = '{2'd2, 1'b1, 1'b1, 32'h0,        32'h00000000, 1'b0};
        tbl[13] = '{2'd3, 1'b1, 1'b0, 32'h000000FF, 32'h00000000, 1'b0};
        tbl[14] = '{2'd3, 1'b1, 1'b1, 32'h0,        32'h00000000, 1'b0};

        in_port = RL;
        bus_idle();
        do_reset();

        // Register access table straight out of reset.
        for (int i = 0; i < 15; i++) begin
            bus_if.address    = tbl[i].addr;
            bus_if.chipselect = tbl[i].cs;
            bus_if.write_n    = tbl[i].wn;
            bus_if.writedata  = tbl[i].wd;
            #1;
            chk($sformatf("tbl%0d_rd", i), bus_if.readdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
            step();
            bus_idle();
        end

        // Glitches on bit 1 shorter than the debounce window are rejected.
        do_reset();
        in_port = 8'hFD; repeat (3) step();
        in_port = 8'hFF; step();
        in_port = 8'hFD; repeat (3) step();
        in_port = 8'hFF; repeat (8) step();
        rd(2'd0, 32'h000000FF, "glitch_data");
        rd(2'd3, 32'h00000000, "glitch_edge");

        // Clean falling edge on bit 0: accepted exactly on edge 2+D.
        do_reset();
        in_port = 8'hFE;
        for (int e = 1; e <= 5; e++) begin
            step();
            rd(2'd0, 32'h000000FF, $sformatf("latency_e%0d", e));
        end
        step();
        rd(2'd0, 32'h000000FE, "latency_e6");
        rd(2'd3, 32'h00000001, "fall_captured");

        // Unmask, clear, then a rising edge that must not be captured.
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        bus_if.address = 2'd2;    bus_if.writedata = 32'h1;
        #1;
        chk("irq_before_unmask", {31'b0, irq}, 32'h0);
        step();
        bus_idle();
        chk("irq_after_unmask", {31'b0, irq}, 32'h1);
        wr_step(2'd3, 32'h1);
        chk("irq_after_clear", {31'b0, irq}, 32'h0);
        rd(2'd3, 32'h00000000, "edge_after_clear");
        in_port = 8'hFF; repeat (8) step();
        rd(2'd0, 32'h000000FF, "rise_data");
        rd(2'd3, 32'h00000000, "rise_not_captured");
        chk("rise_irq", {31'b0, irq}, 32'h0);

        // Falling edge on bit 2 coinciding with a clear of bit 2: set wins.
        in_port = 8'hFB; repeat (5) step();
        rd(2'd0, 32'h000000FF, "setwin_pre");
        wr_step(2'd3, 32'h4);
        rd(2'd0, 32'h000000FB, "setwin_data");
        rd(2'd3, 32'h00000004, "setwin_edge");

        // Reset mid-count on bit 3, then confirm the counter restarts from zero.
        do_reset();
        in_port = 8'hF7; repeat (4) step();
        reset = 1'b1;
        model_reset();
        in_port = 8'hFF;
        rd(2'd0, 32'h000000FF, "midrst_data");
        rd(2'd3, 32'h00000000, "midrst_edge");
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) step();
        rd(2'd0, 32'h000000FF, "postrst_data");
        rd(2'd3, 32'h00000000, "postrst_edge");
        chk("postrst_irq", {31'b0, irq}, 32'h0);
        in_port = 8'hF7; repeat (5) step();
        rd(2'd0, 32'h000000FF, "postrst_count_e5");
        step();
        rd(2'd0, 32'h000000F7, "postrst_count_e6");
        rd(2'd3, 32'h00000008, "postrst_edge3");

        // Randomized traffic against the reference model.
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic [W-1:0] flips;
            if (cyc == 400) begin
                bus_idle();
                do_reset();
            end
            flips = '0;
            for (int b = 0; b < W; b++) if ($urandom_range(0, 7) == 0) flips[b] = 1'b1;
            in_port = in_port ^ flips;
            bus_if.chipselect = 1'($urandom_range(0, 1));
            bus_if.write_n    = ($urandom_range(0, 3) != 0);
            bus_if.address    = 2'($urandom_range(0, 3));
            bus_if.writedata  = $urandom;
            #1;
            chk("rand_rd", bus_if.readdata, model_rd());
            chk("rand_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
            step();
        end
        bus_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unsaved_button_capture.md
Name: unsaved_button_capture

Overview:
- Avalon-MM slave input port for the push-buttons; upstream partner of the 8-bit output PIO on the same slave bus.
- Per-bit path: 2-flop synchroniser, then counter debouncer, then edge-capture register with a maskable interrupt to the processor.
- Software reads debounced levels, enables/masks interrupts, and clears captured edges.

Parameters:
- WIDTH, 8: number of button inputs.
- DEBOUNCE_CYCLES, 16: consecutive clocks a synchronised change must persist before it is accepted; ≥2. Counter width = clog2(DEBOUNCE_CYCLES).
- EDGE_TYPE, 1: edge captured. 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, all ones (WIDTH bits): reset value of the synchroniser flops and the debounced level. Buttons are active-low.

Ports:
- clk, in, 1: single clock for all logic.
- reset, in, 1: asynchronous, active-high reset.
- address, in, 2: register select.
- chipselect, in, 1: slave select.
- write_n, in, 1: active-low write strobe.
- writedata, in, 32: write data.
- in_port, in, WIDTH: raw asynchronous button inputs.
- readdata, out, 32: read data, zero read latency.
- irq, out, 1: level interrupt.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high, named reset.
  - On reset: sync1, sync2 and stable = RESET_LEVEL; all debounce counters = 0; edge_capture = 0; irq_mask = 0. Hence irq = 0 and readdata reflects RESET_LEVEL at address 0.
  - Reset asserted mid-debounce discards any partial count. No edge is captured on reset release.
- Synchroniser: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit, on each edge:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency and glitch rejection:
  - A clean change on in_port that settles before edge 1 appears in stable after edge 2+DEBOUNCE_CYCLES.
  - Any pulse shorter than DEBOUNCE_CYCLES synchronised cycles is rejected; the counter restarts from 0 on every bounce back.
- Edge capture: on the edge where stable[i] updates, edge_capture[i] <= 1 if the transition matches EDGE_TYPE. Falling = 1→0, rising = 0→1, any = both.
- Register map (address):
  - 0, data: RO. readdata = zero-extended stable. Writes ignored.
  - 1: reserved. Reads 0, writes ignored.
  - 2, irq_mask: RW, WIDTH bits. Written when chipselect && !write_n && address==2, from writedata[WIDTH-1:0].
  - 3, edge_capture: read returns captured bits. Write-1-to-clear per bit: bit i cleared when writedata[i]==1; bits written 0 unchanged.
- Write-clear vs new edge: a clear and a new edge on the same bit in the same cycle leave the bit set (set wins). Different bits are independent.
- Read path: readdata is combinational from address, the same cycle chipselect is high. When chipselect is low, readdata = 0. Upper 32-WIDTH bits are always 0.
- Interrupt: irq = |(edge_capture & irq_mask), combinational from registers.
  - Unmasking an already-captured bit raises irq in the cycle after the mask write.
  - Masking leaves edge_capture unchanged.
- No bus wait states; every access completes in one cycle.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, EDGE_TYPE=1, WIDTH=8.
1. Reset, then read address 0 → readdata=32'h000000FF; irq=0; read address 3 → 0.
2. Drive in_port[0] 1→0 cleanly at edge 0 → stable[0] is 1 after edge 5 and 0 after edge 6; read address 0 → 32'h000000FE; address 3 → 32'h00000001.
3. Glitch in_port[1] low for 3 cycles, repeated twice with 1 high cycle between → stable and edge_capture unchanged (0xFF, 0x00).
4. Write 0x01 to address 2 after scenario 2 → irq=1 next cycle. Write 0x01 to address 3 → edge_capture=0, irq=0 next cycle. Release in_port[0] (rising edge) → no capture, irq stays 0.
5. Force a falling edge on bit 2 to land in the same cycle as a write of 0x04 to address 3 → edge_capture[2]=1 afterwards.
6. Assert reset while bit 3 counter is at 2 → counter=0, stable=0xFF, edge_capture=0. After release, hold in_port=0xFF → no edges, irq=0.
